// File: rtl/dmem_access_unit.sv
// Data-memory access unit. It takes one load/store command from the control FSM,
// checks the size and alignment, drives a request/ack memory handshake with a
// timeout, and delivers the extended load result in the memory data register (mdr).
module dmem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        wr,
  input  logic [2:0]  funct3,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_be,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic [63:0] mdr,
  output logic        busy,
  output logic        done,
  output logic        err_align,
  output logic        err_timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t        state;
  logic          wr_q;
  logic [2:0]    funct3_q;
  logic [63:0]   addr_q;
  logic [CW-1:0] cnt;

  logic [7:0]    size_mask;
  logic          aligned;
  logic          illegal;
  logic [63:0]   lane;
  logic [63:0]   load_ext;

  // The address is held from the latched command; only the doubleword index goes out.
  assign mem_addr = {addr_q[63:3], 3'b000};
  assign busy     = (state != IDLE);

  // Decode the incoming command: byte mask for the access size, alignment, legality.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    size_mask = 8'h00;
    aligned   = 1'b0;
    case (funct3[1:0])
      2'b00: begin size_mask = 8'h01; aligned = 1'b1;                end
      2'b01: begin size_mask = 8'h03; aligned = (addr[0]   == 1'b0); end
      2'b10: begin size_mask = 8'h0F; aligned = (addr[1:0] == 2'b0); end
      2'b11: begin size_mask = 8'hFF; aligned = (addr[2:0] == 3'b0); end
      default: ;
    endcase
    illegal = wr ? funct3[2] : (funct3 == 3'b111);
  end

  // Pick the addressed byte lane(s) out of the read doubleword and extend them.
  always_comb begin
    lane     = mem_rdata >> {addr_q[2:0], 3'b000};
    load_ext = lane;
    case (funct3_q)
      3'b000:  load_ext = {{56{lane[7]}},  lane[7:0]};
      3'b001:  load_ext = {{48{lane[15]}}, lane[15:0]};
      3'b010:  load_ext = {{32{lane[31]}}, lane[31:0]};
      3'b100:  load_ext = {56'b0, lane[7:0]};
      3'b101:  load_ext = {48'b0, lane[15:0]};
      3'b110:  load_ext = {32'b0, lane[31:0]};
      default: load_ext = lane;
    endcase
  end

  // Control FSM with registered memory-side outputs and status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      wr_q        <= 1'b0;
      funct3_q    <= 3'b0;
      addr_q      <= 64'b0;
      cnt         <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_be      <= 8'h00;
      mem_wdata   <= 64'b0;
      mdr         <= 64'b0;
      done        <= 1'b0;
      err_align   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here sees the
      // pre-edge values of the others regardless of statement order.
      done        <= 1'b0;
      err_align   <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            wr_q     <= wr;
            funct3_q <= funct3;
            addr_q   <= addr;
            cnt      <= '0;
            if (illegal || !aligned) begin
              state     <= DONE;
              done      <= 1'b1;
              err_align <= 1'b1;
            end else begin
              state     <= REQ;
              mem_req   <= 1'b1;
              mem_we    <= wr;
              mem_be    <= size_mask << addr[2:0];
              mem_wdata <= wdata << {addr[2:0], 3'b000};
            end
          end
        end
        REQ: begin
          // An ack in the final allowed cycle still counts as success.
          if (mem_ack || cnt == CW'(TIMEOUT - 1)) begin
            state       <= DONE;
            done        <= 1'b1;
            err_timeout <= !mem_ack;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_be      <= 8'h00;
            mem_wdata   <= 64'b0;
            if (mem_ack && !wr_q) mdr <= load_ext;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: directed scenarios plus randomized
// loads/stores compared against a size/offset arithmetic model of the access rules.
module tb_dmem_access_unit;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset, start, wr, mem_ack;
  logic [2:0]  funct3;
  logic [63:0] addr, wdata, mem_rdata;
  logic        mem_req, mem_we, busy, done, err_align, err_timeout;
  logic [63:0] mem_addr, mem_wdata, mdr;
  logic [7:0]  mem_be;

  int          tests = 0;
  int          fails = 0;
  logic [63:0] exp_mdr;

  dmem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .wr(wr), .funct3(funct3),
    .addr(addr), .wdata(wdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mdr(mdr), .busy(busy),
    .done(done), .err_align(err_align), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Reference load result: take 'size' bytes starting at byte 'off', then extend.
  function automatic logic [63:0] load_value(input logic [2:0] f, input int off,
                                             input logic [63:0] rd);
    int          size = 1 << f[1:0];
    logic [63:0] v    = rd >> (8 * off);
    logic [63:0] mask;
    if (size < 8) begin
      mask = (64'h1 << (8 * size)) - 64'h1;
      v    = v & mask;
      if (!f[2] && v[8 * size - 1]) v = v | ~mask;
    end
    return v;
  endfunction

  // Present a command for one cycle (called at a negedge); scramble inputs afterwards.
  task automatic drive_start(input logic w, input logic [2:0] f,
                             input logic [63:0] a, input logic [63:0] d);
    start = 1'b1; wr = w; funct3 = f; addr = a; wdata = d;
    @(negedge clk);
    start = 1'b0; wr = 1'($urandom); funct3 = 3'($urandom); addr = rnd64(); wdata = rnd64();
  endtask

  // One complete transaction; ack_wait = REQ cycles before ack (>= TIMEOUT means never).
  task automatic run_txn(input logic w, input logic [2:0] f, input logic [63:0] a,
                         input logic [63:0] d, input logic [63:0] rd, input int ack_wait);
    int          size = 1 << f[1:0];
    int          off  = int'(a[2:0]);
    bit          legal, ok, finished;
    int          k;
    logic [7:0]  exp_be;
    legal  = w ? !f[2] : (f != 3'b111);
    ok     = legal && ((off % size) == 0);
    exp_be = 8'(((1 << size) - 1) << off);
    drive_start(w, f, a, d);
    if (!ok) begin
      check("err_done",      done,        1'b1);
      check("err_align",     err_align,   1'b1);
      check("err_no_tmo",    err_timeout, 1'b0);
      check("err_no_req",    mem_req,     1'b0);
      check("err_be",        mem_be,      8'h00);
      check("err_mdr",       mdr,         exp_mdr);
      @(negedge clk);
      check("err_done_off",  done,        1'b0);
      check("err_align_off", err_align,   1'b0);
      check("err_idle",      busy,        1'b0);
      return;
    end
    check("req_addr",  mem_addr,  a & ~64'h7);
    check("req_we",    mem_we,    w);
    check("req_be",    mem_be,    exp_be);
    check("req_wdata", mem_wdata, d << (8 * off));
    check("req_busy",  busy,      1'b1);
    check("req_ndone", done,      1'b0);
    k = 0;
    finished = 0;
    while (!finished) begin
      check("req_held", mem_req, 1'b1);
      if (k == ack_wait) begin
        mem_ack = 1'b1; mem_rdata = rd;
      end else begin
        mem_ack = 1'b0; mem_rdata = rnd64();
      end
      @(negedge clk);
      mem_ack = 1'b0;
      if (k == ack_wait) begin
        if (!w) exp_mdr = load_value(f, off, rd);
        check("ack_done", done,        1'b1);
        check("ack_ntmo", err_timeout, 1'b0);
        check("ack_nal",  err_align,   1'b0);
        check("ack_mdr",  mdr,         exp_mdr);
        finished = 1;
      end else if (k == TIMEOUT - 1) begin
        check("tmo_done", done,        1'b1);
        check("tmo_flag", err_timeout, 1'b1);
        check("tmo_mdr",  mdr,         exp_mdr);
        finished = 1;
      end
      k++;
    end
    check("end_req",   mem_req,   1'b0);
    check("end_we",    mem_we,    1'b0);
    check("end_be",    mem_be,    8'h00);
    check("end_wdata", mem_wdata, 64'h0);
    @(negedge clk);
    check("post_done", done,        1'b0);
    check("post_tmo",  err_timeout, 1'b0);
    check("post_busy", busy,        1'b0);
  endtask

  initial begin
    logic [63:0] r;
    reset = 1'b1; start = 1'b0; wr = 1'b0; funct3 = 3'b0; addr = 64'h0;
    wdata = 64'h0; mem_ack = 1'b0; mem_rdata = 64'h0; exp_mdr = 64'h0;
    repeat (2) @(negedge clk);
    check("rst_req",  mem_req,     1'b0);
    check("rst_we",   mem_we,      1'b0);
    check("rst_be",   mem_be,      8'h00);
    check("rst_busy", busy,        1'b0);
    check("rst_done", done,        1'b0);
    check("rst_al",   err_align,   1'b0);
    check("rst_tmo",  err_timeout, 1'b0);
    check("rst_mdr",  mdr,         64'h0);
    reset = 1'b0;
    @(negedge clk);

    // ld, zero-wait ack
    run_txn(1'b0, 3'b011, 64'h1000, 64'h0, 64'h8877665544332211, 0);
    check("ld_mdr", mdr, 64'h8877665544332211);
    // lb / lbu of a byte with its top bit set, ack after 3 waits
    run_txn(1'b0, 3'b000, 64'h1003, 64'h0, 64'h1234567880ABCDEF, 3);
    check("lb_mdr", mdr, 64'hFFFFFFFFFFFFFF80);
    run_txn(1'b0, 3'b100, 64'h1003, 64'h0, 64'h1234567880ABCDEF, 3);
    check("lbu_mdr", mdr, 64'h80);
    // sh to the top half-word; mdr untouched
    run_txn(1'b1, 3'b001, 64'h2006, 64'hBEEF, rnd64(), 1);
    check("sh_mdr", mdr, 64'h80);
    // misaligned lw, illegal load and store encodings
    run_txn(1'b0, 3'b010, 64'h1002, 64'h0, rnd64(), 0);
    run_txn(1'b0, 3'b111, 64'h1000, 64'h0, rnd64(), 0);
    run_txn(1'b1, 3'b100, 64'h1000, 64'h0, rnd64(), 0);
    check("bad_mdr", mdr, 64'h80);
    // no ack -> timeout; then ack in the last allowed cycle wins
    run_txn(1'b0, 3'b011, 64'h3000, 64'h0, rnd64(), 1000);
    run_txn(1'b0, 3'b011, 64'h3008, 64'h0, 64'hCAFEF00D12345678, TIMEOUT - 1);
    check("late_ack_mdr", mdr, 64'hCAFEF00D12345678);

    // second start while busy is ignored
    drive_start(1'b0, 3'b011, 64'h5008, 64'h0);
    start = 1'b1; wr = 1'b1; funct3 = 3'b000; addr = 64'h6001;
    @(negedge clk);
    start = 1'b0;
    check("ign_addr", mem_addr, 64'h5008);
    check("ign_we",   mem_we,   1'b0);
    check("ign_be",   mem_be,   8'hFF);
    r = rnd64();
    mem_ack = 1'b1; mem_rdata = r;
    @(negedge clk);
    mem_ack = 1'b0;
    exp_mdr = r;
    check("ign_done", done, 1'b1);
    check("ign_mdr",  mdr,  exp_mdr);
    @(negedge clk);
    check("ign_idle", busy,    1'b0);
    check("ign_nreq", mem_req, 1'b0);
    check("ign_ndn",  done,    1'b0);

    // ack while idle does nothing
    mem_ack = 1'b1; mem_rdata = rnd64();
    @(negedge clk);
    mem_ack = 1'b0;
    check("idle_ack_mdr",  mdr,  exp_mdr);
    check("idle_ack_done", done, 1'b0);
    check("idle_ack_busy", busy, 1'b0);

    // reset in the middle of a request
    drive_start(1'b0, 3'b011, 64'h4000, 64'h0);
    @(negedge clk);
    check("mid_req", mem_req, 1'b1);
    reset = 1'b1;
    #1;
    exp_mdr = 64'h0;
    check("mid_rst_req",  mem_req, 1'b0);
    check("mid_rst_busy", busy,    1'b0);
    check("mid_rst_be",   mem_be,  8'h00);
    check("mid_rst_mdr",  mdr,     exp_mdr);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      check("mid_rst_ndone", done, 1'b0);
      check("mid_rst_idle",  busy, 1'b0);
    end

    // randomized mix of loads, stores, bad commands, waits and timeouts
    for (int n = 0; n < 80; n++) begin
      int wait_c;
      wait_c = ($urandom_range(0, 9) == 0) ? 40 : int'($urandom_range(0, 5));
      if ($urandom_range(0, 9) == 0) wait_c = TIMEOUT - 1;
      run_txn(1'($urandom), 3'($urandom), rnd64(), rnd64(), rnd64(), wait_c);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_access_unit.md
DMEM_ACCESS_UNIT -- requirements
Module: dmem_access_unit

Interface
REQ-001 Parameter TIMEOUT, default 16, maximum cycles mem_req is held waiting for mem_ack before aborting.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle command pulse from control FSM.
REQ-005 wr  input  1  1 = store, 0 = load; sampled with start.
REQ-006 funct3  input  3  access size/sign; sampled with start.
REQ-007 addr  input  64  byte address (ALUOut); sampled with start.
REQ-008 wdata  input  64  store data (register B); sampled with start.
REQ-009 mem_req  output  1  memory request, held until ack or abort.
REQ-010 mem_we  output  1  write strobe, valid while mem_req=1.
REQ-011 mem_addr  output  64  doubleword-aligned address {addr[63:3],3'b000}.
REQ-012 mem_wdata  output  64  store data shifted to byte lane.
REQ-013 mem_be  output  8  byte enables.
REQ-014 mem_ack  input  1  memory completion, single cycle.
REQ-015 mem_rdata  input  64  read doubleword, valid with mem_ack.
REQ-016 mdr  output  64  memory data register (extended load result).
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 done  output  1  one-cycle completion pulse.
REQ-019 err_align  output  1  misaligned access flag, pulsed with done.
REQ-020 err_timeout  output  1  timeout flag, pulsed with done.

Function
REQ-021 States IDLE, REQ, DONE; IDLE->REQ on start with legal aligned command; IDLE->DONE on start with misaligned or illegal command; REQ->DONE on mem_ack or timeout; DONE->IDLE unconditionally.
REQ-022 Command (wr, funct3, addr, wdata) SHALL be latched only on start in IDLE; start while busy SHALL be ignored.
REQ-023 Loads funct3: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu; 111 illegal. Stores: 000 sb, 001 sh, 010 sw, 011 sd; 1xx illegal.
REQ-024 Size 1/2/4/8 bytes; misaligned when addr mod size != 0; misaligned/illegal -> no mem_req, done with err_align=1.
REQ-025 In REQ: mem_req=1, mem_we=wr, mem_be=size mask << addr[2:0], mem_wdata=wdata << 8*addr[2:0]; outputs stable until exit.
REQ-026 On mem_ack in REQ for a load, mdr SHALL load on that edge: byte lane(s) at addr[2:0], sign-extended (lb/lh/lw) or zero-extended (lbu/lhu/lwu/ld) to 64 bits.
REQ-027 Stores SHALL not modify mdr; aborted or erroneous accesses SHALL not modify mdr.
REQ-028 Latency: start at edge N -> mem_req high cycle N+1; ack at edge M -> done high cycle M+1; zero-wait ack gives done two cycles after start.
REQ-029 Timeout counter cleared on REQ entry, increments per REQ cycle without ack; at TIMEOUT cycles mem_req drops, done with err_timeout=1.
REQ-030 mem_ack coincident with the timeout cycle SHALL count as success (ack wins).
REQ-031 mem_ack outside REQ SHALL be ignored.
REQ-032 When mem_req=0, mem_we=0, mem_be=0, mem_wdata=0.
REQ-033 done, err_align, err_timeout SHALL be high only in DONE, exactly one cycle.

Reset
REQ-034 reset SHALL force IDLE immediately: mem_req, mem_we, mem_be, busy, done, err_align, err_timeout=0, mdr=0, counter=0.
REQ-035 Reset mid-REQ SHALL drop mem_req in the same cycle; no done pulse SHALL follow.

Verification
REQ-036 ld, addr=0x1000, mem_rdata=0x8877665544332211, ack 0 wait -> mem_addr=0x1000, mem_be=0xFF, mdr=0x8877665544332211, done 2 cycles after start.
REQ-037 lb, addr=0x1003, rdata byte3=0x80, ack after 3 waits -> mem_be=0x08, mdr=0xFFFFFFFFFFFFFF80; lbu same -> mdr=0x80.
REQ-038 sh, addr=0x2006, wdata=0xBEEF -> mem_we=1, mem_be=0xC0, mem_wdata=0xBEEF000000000000, mdr unchanged.
REQ-039 lw, addr=0x1002 -> no mem_req, done+err_align next cycle, mdr unchanged.
REQ-040 ld, no ack -> mem_req high 16 cycles, then done+err_timeout; repeat with ack on 16th cycle -> success, no error.
REQ-041 reset asserted during REQ -> mem_req low same cycle, busy=0, no done; second start during busy ignored.
